// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART word arbiter.
// Holds the FSM encoding, the ack timeout and the default header base.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  localparam int         ACK_TIMEOUT      = 4;
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes plus byte-transmitter link of the UART word arbiter.
// master = arbiter side, slave = requesters and byte transmitter side.
interface uart_tx_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        grant_id;
  logic        active;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_start, tx_byte, grant_id, active
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_start, tx_byte, grant_id, active
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the
// requester that was not granted last time.
module rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_winner
);
  always_comb begin
    // NOTE: default first so every path assigns o_winner and no latch is inferred.
    o_winner = 1'b0;
    if (i_valid0 && i_valid1) o_winner = ~i_last_grant;
    else if (i_valid1)        o_winner = 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Accepts 32-bit words from two requesters, round-robin, and feeds them
// byte by byte (optional source header first) to a UART byte transmitter.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT
) (
  input  logic             CLK,
  input  logic             reset_n,
  uart_tx_arbiter_if.master bus
);
  localparam int               TMR_W    = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_t           r_state;
  logic [31:0]      r_word;
  logic [1:0]       r_byte_idx;
  logic             r_in_hdr;
  logic             r_armed;
  logic             r_last_grant;
  logic             r_grant;
  logic             r_active;
  logic             r_tx_start;
  logic [7:0]       r_tx_byte;
  logic [TMR_W-1:0] r_timer;

  logic        w_winner;
  logic        w_idle_open;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_xfer;
  logic        w_last_byte;
  logic [7:0]  w_cur_byte;
  logic [31:0] w_win_data;

  rr_arb2 u_rr_arb2 (
    .i_valid0     (bus.req0_valid),
    .i_valid1     (bus.req1_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner)
  );

  // r_armed keeps ready low until the first edge after reset release.
  assign w_idle_open = r_armed && (r_state == ST_IDLE);
  assign w_ready0    = w_idle_open && !w_winner && bus.req0_valid;
  assign w_ready1    = w_idle_open &&  w_winner && bus.req1_valid;
  assign w_xfer      = w_ready0 || w_ready1;
  assign w_win_data  = w_winner ? bus.req1_data : bus.req0_data;
  assign w_cur_byte  = r_in_hdr ? (HDR_BASE | {7'b0, r_grant}) : word_byte(r_word, r_byte_idx);
  assign w_last_byte = !r_in_hdr && (r_byte_idx == 2'd3);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_in_hdr     <= 1'b0;
      r_armed      <= 1'b0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_active     <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_timer      <= '0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge state.
      r_armed    <= 1'b1;
      r_tx_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_word       <= w_win_data;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_active     <= 1'b1;
            r_in_hdr     <= HEADER_EN;
            r_byte_idx   <= '0;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_byte  <= w_cur_byte;
            r_timer    <= '0;
            r_state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (bus.tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_timer == TMR_LAST) begin
            r_tx_start <= 1'b1;
            r_timer    <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (w_last_byte) begin
              r_byte_idx <= '0;
              r_active   <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              if (r_in_hdr) r_in_hdr   <= 1'b0;
              else          r_byte_idx <= r_byte_idx + 2'd1;
              r_state <= ST_SEND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.tx_start   = r_tx_start;
  assign bus.tx_byte    = r_tx_byte;
  assign bus.grant_id   = r_grant;
  assign bus.active     = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one DUT with header bytes, one without,
// each driven by a simple byte-transmitter model that logs every tx_start.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if ifa();
  uart_tx_arbiter_if ifb();

  uart_tx_arbiter #(.HEADER_EN(1'b1), .HDR_BASE(8'hA0)) u_dut_a (.CLK(clk), .reset_n(rst_n), .bus(ifa));
  uart_tx_arbiter #(.HEADER_EN(1'b0), .HDR_BASE(8'hA0)) u_dut_b (.CLK(clk), .reset_n(rst_n), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] log_a[$];
  int         logc_a[$];
  logic [7:0] log_b[$];
  int  dur_a = 10;
  bit  ack_en_a = 1'b1;
  bit  force_a  = 1'b0;
  int  cnt_a = 0, cnt_b = 0, dbl_a = 0, dbl_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  // Transmitter models act at negedge+2; tests drive at negedge and sample at negedge+1.
  initial begin
    ifa.tx_busy = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (ifa.tx_start) begin
        log_a.push_back(ifa.tx_byte);
        logc_a.push_back(cyc);
        if (prev_a) dbl_a++;
        if (ack_en_a) cnt_a = dur_a;
      end
      prev_a = ifa.tx_start;
      if (force_a)        ifa.tx_busy = 1'b1;
      else if (cnt_a > 0) begin ifa.tx_busy = 1'b1; cnt_a--; end
      else                ifa.tx_busy = 1'b0;
    end
  end

  initial begin
    ifb.tx_busy = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (ifb.tx_start) begin
        log_b.push_back(ifb.tx_byte);
        if (prev_b) dbl_b++;
        cnt_b = 3;
      end
      prev_b = ifb.tx_start;
      if (cnt_b > 0) begin ifb.tx_busy = 1'b1; cnt_b--; end
      else           ifb.tx_busy = 1'b0;
    end
  end

  function automatic logic [7:0] at_a(input int i);
    return (i < log_a.size()) ? log_a[i] : 8'hxx;
  endfunction
  function automatic int atc_a(input int i);
    return (i < logc_a.size()) ? logc_a[i] : -1;
  endfunction
  function automatic logic [7:0] at_b(input int i);
    return (i < log_b.size()) ? log_b[i] : 8'hxx;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    force_a = 1'b0; ack_en_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents a word on DUT A and returns the cycle in which ready was seen.
  task automatic send_a(input bit req, input logic [31:0] data, output int acc_cyc);
    int k = 0;
    @(negedge clk);
    if (req) begin ifa.req1_valid = 1'b1; ifa.req1_data = data; end
    else     begin ifa.req0_valid = 1'b1; ifa.req0_data = data; end
    #1;
    while (!(req ? ifa.req1_ready : ifa.req0_ready) && k < 300) begin
      @(negedge clk); #1; k++;
    end
    acc_cyc = cyc;
    n_cmp++;
    if (k >= 300) begin n_bad++; $display("FAIL send_a_accept: req%0d not accepted within 300 cycles", req); end
    @(negedge clk);
    if (req) ifa.req1_valid = 1'b0; else ifa.req0_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, output int idle_cyc);
    int k = 0;
    do begin @(negedge clk); #1; k++; end while (ifa.active && k < 2000);
    idle_cyc = cyc;
    n_cmp++;
    if (ifa.active !== 1'b0) begin n_bad++; $display("FAIL %s_idle: active=%b want 0 after %0d cycles", tag, ifa.active, k); end
  endtask

  task automatic test_reset();
    ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
    repeat (2) @(negedge clk); #1;
    n_cmp++; if (ifa.tx_start !== 1'b0)  begin n_bad++; $display("FAIL rst_tx_start: got %b want 0", ifa.tx_start); end
    n_cmp++; if (ifa.tx_byte !== 8'h00)  begin n_bad++; $display("FAIL rst_tx_byte: got %h want 00", ifa.tx_byte); end
    n_cmp++; if (ifa.grant_id !== 1'b0)  begin n_bad++; $display("FAIL rst_grant: got %b want 0", ifa.grant_id); end
    n_cmp++; if (ifa.active !== 1'b0)    begin n_bad++; $display("FAIL rst_active: got %b want 0", ifa.active); end
    n_cmp++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", {ifa.req0_ready, ifa.req1_ready}); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (ifa.req0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_ready: got %b want 0 before first edge", ifa.req0_ready); end
    @(negedge clk); #1;
    n_cmp++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) begin n_bad++; $display("FAIL rst_priority: got %b want 10", {ifa.req0_ready, ifa.req1_ready}); end
    ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (ifa.active !== 1'b0) begin n_bad++; $display("FAIL rst_no_capture: active=%b want 0", ifa.active); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp[5] = '{8'hA0, 8'h44, 8'h33, 8'h22, 8'h11};
    int acc, idle;
    log_a.delete(); logc_a.delete(); dur_a = 10;
    send_a(1'b0, 32'h11223344, acc);
    #1;
    n_cmp++; if (ifa.grant_id !== 1'b0) begin n_bad++; $display("FAIL single_grant: got %b want 0", ifa.grant_id); end
    n_cmp++; if (ifa.active !== 1'b1)   begin n_bad++; $display("FAIL single_active: got %b want 1", ifa.active); end
    wait_idle_a("single", idle);
    n_cmp++; if (log_a.size() != 5) begin n_bad++; $display("FAIL single_count: got %0d bytes want 5", log_a.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (at_a(i) !== exp[i]) begin n_bad++; $display("FAIL single_byte%0d: got %h want %h", i, at_a(i), exp[i]); end
    end
    // Ready seen in cycle k -> transfer edge -> SEND cycle -> tx_start visible in k+2.
    n_cmp++; if (atc_a(0) != acc + 2)  begin n_bad++; $display("FAIL single_latency: tx_start cycle %0d want %0d", atc_a(0), acc + 2); end
    // 10 busy cycles: byte-to-byte spacing 12, last tx_start to idle 11.
    n_cmp++; if (atc_a(1) - atc_a(0) != 12) begin n_bad++; $display("FAIL single_spacing: got %0d want 12", atc_a(1) - atc_a(0)); end
    n_cmp++; if (idle - atc_a(4) != 11)     begin n_bad++; $display("FAIL single_active_fall: got %0d want 11", idle - atc_a(4)); end
  endtask

  task automatic test_contention();
    int k, idle;
    do_reset();
    log_a.delete(); logc_a.delete(); dur_a = 2;
    ifa.req0_valid = 1'b1; ifa.req0_data = 32'hAABBCC01;
    ifa.req1_valid = 1'b1; ifa.req1_data = 32'h55667702;
    for (int i = 0; i < 4; i++) begin
      k = 0; #1;
      while (!(ifa.req0_ready || ifa.req1_ready) && k < 300) begin @(negedge clk); #1; k++; end
      n_cmp++;
      if (k >= 300 || ifa.req1_ready !== 1'(i % 2)) begin
        n_bad++; $display("FAIL contention_grant%0d: ready0=%b ready1=%b want winner %0d", i, ifa.req0_ready, ifa.req1_ready, i % 2);
      end
      @(negedge clk);
    end
    ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    wait_idle_a("contention", idle);
    n_cmp++; if (log_a.size() != 20) begin n_bad++; $display("FAIL contention_count: got %0d want 20", log_a.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (at_a(5*i) !== (8'hA0 | 8'(i % 2))) begin n_bad++; $display("FAIL contention_hdr%0d: got %h want %h", i, at_a(5*i), 8'hA0 | 8'(i % 2)); end
      n_cmp++; if (at_a(5*i+1) !== 8'(1 + i % 2))    begin n_bad++; $display("FAIL contention_b0_%0d: got %h want %h", i, at_a(5*i+1), 8'(1 + i % 2)); end
    end
  endtask

  task automatic test_valid_drop();
    int acc, idle, seen = 0;
    log_a.delete(); logc_a.delete(); dur_a = 10;
    send_a(1'b0, 32'h01020304, acc);
    ifa.req1_valid = 1'b1; ifa.req1_data = 32'hFFFFFFFF;
    repeat (20) begin #1; if (ifa.req1_ready) seen++; @(negedge clk); end
    ifa.req1_valid = 1'b0;
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL drop_ready_busy: ready1 high %0d cycles want 0", seen); end
    wait_idle_a("drop", idle);
    repeat (3) @(negedge clk);
    n_cmp++; if (log_a.size() != 5) begin n_bad++; $display("FAIL drop_count: got %0d bytes want 5", log_a.size()); end
    n_cmp++; if (at_a(1) !== 8'h04) begin n_bad++; $display("FAIL drop_byte0: got %h want 04", at_a(1)); end
    ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1; #1;
    n_cmp++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b01) begin n_bad++; $display("FAIL drop_pointer: got %b want 01", {ifa.req0_ready, ifa.req1_ready}); end
    ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    repeat (3) @(negedge clk); #1;
    n_cmp++; if (ifa.active !== 1'b0) begin n_bad++; $display("FAIL drop_no_capture: active=%b want 0", ifa.active); end
  endtask

  task automatic test_busy_hold();
    int acc, idle;
    dur_a = 10;
    @(negedge clk); force_a = 1'b1;
    repeat (2) @(negedge clk);
    log_a.delete(); logc_a.delete();
    send_a(1'b0, 32'h0A0B0C0D, acc);
    repeat (20) @(negedge clk); #1;
    n_cmp++; if (log_a.size() != 0) begin n_bad++; $display("FAIL busy_hold_quiet: got %0d pulses want 0", log_a.size()); end
    force_a = 1'b0;
    repeat (6) @(negedge clk); #1;
    n_cmp++; if (log_a.size() != 1)  begin n_bad++; $display("FAIL busy_hold_once: got %0d pulses want 1", log_a.size()); end
    n_cmp++; if (at_a(0) !== 8'hA0) begin n_bad++; $display("FAIL busy_hold_byte: got %h want a0", at_a(0)); end
    wait_idle_a("busy_hold", idle);
    n_cmp++; if (at_a(4) !== 8'h0A) begin n_bad++; $display("FAIL busy_hold_last: got %h want 0a", at_a(4)); end
  endtask

  task automatic test_missing_ack();
    logic [7:0] exp[8] = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h10, 8'h32, 8'h54, 8'h76};
    int acc, idle, k = 0;
    dur_a = 3; ack_en_a = 1'b0;
    log_a.delete(); logc_a.delete();
    send_a(1'b0, 32'h76543210, acc);
    while (log_a.size() == 0 && k < 50) begin @(negedge clk); #1; k++; end
    n_cmp++; if (log_a.size() == 0) begin n_bad++; $display("FAIL ack_first_pulse: got 0 pulses want 1"); end
    repeat (10) @(negedge clk);
    ack_en_a = 1'b1;
    wait_idle_a("missing_ack", idle);
    n_cmp++; if (log_a.size() != 8) begin n_bad++; $display("FAIL ack_count: got %0d want 8", log_a.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (at_a(i) !== exp[i]) begin n_bad++; $display("FAIL ack_byte%0d: got %h want %h", i, at_a(i), exp[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (atc_a(i) - atc_a(i-1) != 4) begin n_bad++; $display("FAIL ack_retry_gap%0d: got %0d want 4", i, atc_a(i) - atc_a(i-1)); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp[5] = '{8'hA0, 8'h66, 8'h77, 8'h88, 8'h99};
    int acc, idle, k = 0;
    dur_a = 10; log_a.delete(); logc_a.delete();
    send_a(1'b0, 32'h11223344, acc);
    while (log_a.size() < 3 && k < 200) begin @(negedge clk); #1; k++; end
    n_cmp++; if (log_a.size() < 3) begin n_bad++; $display("FAIL midrst_progress: got %0d bytes want 3", log_a.size()); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    ifa.req0_valid = 1'b1; ifa.req0_data = 32'h99887766;
    #1;
    n_cmp++; if ({ifa.tx_start, ifa.tx_byte, ifa.grant_id, ifa.active, ifa.req0_ready, ifa.req1_ready} !== 13'h0)
      begin n_bad++; $display("FAIL midrst_outputs: start=%b byte=%h grant=%b active=%b ready=%b%b want all 0",
        ifa.tx_start, ifa.tx_byte, ifa.grant_id, ifa.active, ifa.req0_ready, ifa.req1_ready); end
    repeat (2) @(negedge clk);
    log_a.delete(); logc_a.delete();
    rst_n = 1'b1;
    send_a(1'b0, 32'h99887766, acc);
    wait_idle_a("midrst", idle);
    n_cmp++; if (log_a.size() != 5) begin n_bad++; $display("FAIL midrst_count: got %0d want 5", log_a.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (at_a(i) !== exp[i]) begin n_bad++; $display("FAIL midrst_byte%0d: got %h want %h", i, at_a(i), exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
    int k = 0;
    log_b.delete();
    @(negedge clk);
    ifb.req1_valid = 1'b1; ifb.req1_data = 32'hDEADBEEF; #1;
    while (!ifb.req1_ready && k < 300) begin @(negedge clk); #1; k++; end
    n_cmp++; if (k >= 300) begin n_bad++; $display("FAIL b2b_first_accept: ready1=%b want 1", ifb.req1_ready); end
    @(negedge clk);
    ifb.req1_data = 32'h00000001;
    k = 0;
    do begin @(negedge clk); #1; k++; end while (ifb.active && k < 500);
    n_cmp++; if (ifb.req1_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_idle: ready1=%b want 1", ifb.req1_ready); end
    @(negedge clk);
    ifb.req1_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); #1; k++; end while (ifb.active && k < 500);
    n_cmp++; if (log_b.size() != 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", log_b.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (at_b(i) !== exp[i]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, at_b(i), exp[i]); end
    end
  endtask

  task automatic test_no_double_pulse();
    n_cmp++; if (dbl_a != 0) begin n_bad++; $display("FAIL double_pulse_a: got %0d want 0", dbl_a); end
    n_cmp++; if (dbl_b != 0) begin n_bad++; $display("FAIL double_pulse_b: got %0d want 0", dbl_b); end
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.req0_valid = 1'b0; ifa.req0_data = '0; ifa.req1_valid = 1'b0; ifa.req1_data = '0;
    ifb.req0_valid = 1'b0; ifb.req0_data = '0; ifb.req1_valid = 1'b0; ifb.req1_data = '0;
    test_reset();
    test_single_word();
    test_contention();
    test_valid_drop();
    test_busy_hold();
    test_missing_ack();
    test_reset_mid_word();
    test_back_to_back();
    test_no_double_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: HEADER_EN, default 1, meaning 1 = send one source-header byte before each word.
REQ-002 Parameter: HDR_BASE, default 8'hA0, meaning header byte = HDR_BASE | {7'b0, grant_id}.
REQ-003 Port: CLK  input  1  sole clock; all state changes on posedge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req0_valid  input  1  requester 0 has a word.
REQ-006 Port: req0_data  input  32  requester 0 word.
REQ-007 Port: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 Port: req1_valid, req1_data, req1_ready  in/in/out  1/32/1  same roles for requester 1.
REQ-009 Port: tx_start  output  1  one-cycle pulse launching one byte on the byte transmitter.
REQ-010 Port: tx_byte  output  8  byte to send; valid while tx_start=1.
REQ-011 Port: tx_busy  input  1  byte transmitter busy; rises after tx_start, falls after stop bit.
REQ-012 Port: grant_id  output  1  requester currently owning the transmitter.
REQ-013 Port: active  output  1  high from word acceptance until its last byte completes.

Function
REQ-014 States: IDLE, SEND, WAIT_ACK, WAIT_DONE; the encoding is internal.
REQ-015 reqN_ready is combinational: it is high only in IDLE, and only for the arbitration winner. The transfer occurs when reqN_valid and reqN_ready are both high.
REQ-016 Arbitration is round-robin. If only one requester is valid, it wins. If both are valid, the requester not granted last time wins. After reset, requester 0 has priority.
REQ-017 On transfer, the arbiter captures reqN_data, sets grant_id=N, sets active=1, and enters SEND on the next cycle.
REQ-018 Byte order: header byte first (if HEADER_EN=1), then data[7:0], [15:8], [23:16], [31:24]. A 2-bit byte index tracks the position and wraps 3->0 only at word end.
REQ-019 SEND: when tx_busy=0, pulse tx_start for 1 cycle with tx_byte = current byte, then go to WAIT_ACK. If tx_busy=1, the arbiter holds in SEND without pulsing.
REQ-020 WAIT_ACK: when tx_busy=1, go to WAIT_DONE. If tx_busy stays 0 for 4 cycles, tx_start is re-issued once with the same byte; further timeouts repeat this retry.
REQ-021 WAIT_DONE: when tx_busy=0, advance to the next byte in SEND. After the last byte, go to IDLE and clear active in the same edge.
REQ-022 Minimum latency is 1 cycle from transfer to the first tx_start, provided tx_busy=0.
REQ-023 In the IDLE return cycle, a new word may be accepted immediately; no dead cycle is inserted between words.
REQ-024 If valid falls before ready, nothing is captured and the round-robin pointer is unchanged.
REQ-025 Valid changes on either requester during SEND/WAIT_* have no effect; the other requester waits until IDLE.
REQ-026 tx_start is never high for two consecutive cycles.

Reset
REQ-027 Asserting reset_n low at any time, including mid-word, forces IDLE immediately and abandons any partial word.
REQ-028 Reset values: tx_start=0, tx_byte=8'h00, grant_id=0, active=0, req0_ready=0, req1_ready=0, byte index=0, round-robin pointer=favor requester 0.
REQ-029 Outputs leave reset values only on the first CLK edge after reset_n rises.

Structure
REQ-030 A shared package holds the state encoding, the WAIT_ACK timeout constant (4), and the HDR_BASE default.
REQ-031 Round-robin selection is one sub-module, rr_arb2: inputs are 2 valids and the last grant; the output is the winner. It is purely combinational.
REQ-032 Serializer, state machine and timeout counter reside in uart_tx_arbiter.

Verification
REQ-033 Single word: req0 0x11223344, HEADER_EN=1, tx_busy model 10 cycles/byte -> tx_byte sequence A0,44,33,22,11; active falls after 5th byte.
REQ-034 Contention: req0 and req1 both valid, from reset -> req0 granted first, req1 next (header A1); with both held valid, grants alternate 0,1,0,1.
REQ-035 Busy hold: tx_busy=1 at SEND entry for 20 cycles -> no tx_start until tx_busy falls, then exactly one pulse.
REQ-036 Missing ack: tx_busy held 0 after tx_start -> same byte re-pulsed after 4 cycles; no byte skipped.
REQ-037 Reset mid-word: reset_n low after 2nd data byte -> outputs at reset values immediately; next word starts with header byte and byte 0.
REQ-038 HEADER_EN=0, back-to-back req1 words 0xDEADBEEF, 0x00000001 -> bytes EF,BE,AD,DE,01,00,00,00; second ready in the IDLE cycle right after the first word ends.
